// File: rtl/svnet_pkg.sv
// Shared constants and helpers for the svnet reduction datapath.
// The pad value is the signed maximum, so padded slots never win a min-reduction.
package svnet_pkg;

   localparam int SVNET_TREE_PACK_DELAY = 1;

   // Signed maximum of 'width' bits; zero for a single-bit word.
   function automatic logic [63:0] svnet_pad_max(input int width);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < width - 1) r[i] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/svnet_tree_pack_if.sv
// Serial word input and packed vector output of the tree-pack producer.
// o_count exists only when SVNET_TREE_PACK_COUNT_EN is defined.
interface svnet_tree_pack_if #(
   parameter int WIDTH = 1,
   parameter int COUNT = 1
);
   localparam int CW = $clog2(COUNT + 1);

   logic                         i_data_valid;
   logic [WIDTH-1:0]             i_data;
   logic                         i_last;
   logic                         o_data_valid;
   logic [COUNT-1:0][WIDTH-1:0]  o_data;
`ifdef SVNET_TREE_PACK_COUNT_EN
   logic [CW-1:0]                o_count;

   modport master (output i_data_valid, i_data, i_last,
                   input  o_data_valid, o_data, o_count);
   modport slave  (input  i_data_valid, i_data, i_last,
                   output o_data_valid, o_data, o_count);
`else
   modport master (output i_data_valid, i_data, i_last,
                   input  o_data_valid, o_data);
   modport slave  (input  i_data_valid, i_data, i_last,
                   output o_data_valid, o_data);
`endif

endinterface

// File: rtl/svnet_tree_pack.sv
// Packs serial signed words into COUNT-wide vectors, padding short groups; 1-cycle latency, no backpressure.
// Optional o_count of real elements under SVNET_TREE_PACK_COUNT_EN.
module svnet_tree_pack
   import svnet_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int COUNT = 1
)(
   input  logic              clk,
   input  logic              rst,
   svnet_tree_pack_if.slave  bus
);

   localparam int               IW       = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [63:0]      PAD_FULL = svnet_pad_max(WIDTH);
   localparam logic [WIDTH-1:0] PAD      = PAD_FULL[WIDTH-1:0];

   logic [COUNT-1:0][WIDTH-1:0] buf_q;
   logic [COUNT-1:0][WIDTH-1:0] merged;
   logic [IW-1:0]               idx;
   logic                        close;

   // Slots above idx are always PAD, so merging the new word yields the padded vector directly.
   always_comb begin
      close  = bus.i_data_valid && ((idx == IW'(COUNT - 1)) || bus.i_last);
      merged = buf_q;
      for (int i = 0; i < COUNT; i++) begin
         if (idx == IW'(i)) merged[i] = bus.i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q <= {COUNT{PAD}};
         idx   <= '0;
      end else if (bus.i_data_valid) begin
         if (close) begin
            buf_q <= {COUNT{PAD}};
            idx   <= '0;
         end else begin
            buf_q <= merged;
            idx   <= idx + IW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.o_data_valid <= 1'b0;
         bus.o_data       <= {COUNT{PAD}};
`ifdef SVNET_TREE_PACK_COUNT_EN
         bus.o_count      <= '0;
`endif
      end else begin
         bus.o_data_valid <= close;
         if (close) begin
            bus.o_data <= merged;
`ifdef SVNET_TREE_PACK_COUNT_EN
            bus.o_count <= $bits(bus.o_count)'(idx) + $bits(bus.o_count)'(1);
`endif
         end
      end
   end

endmodule

// File: doc/svnet_tree_pack.md
Name: svnet_tree_pack

Overview:
- Producer side of the tree-reduction input interface.
- Collects a serial stream of WIDTH-bit signed words into one COUNT-element vector and emits it with a single-cycle valid pulse.
- The output feeds a tree reducer's `i_data_valid` / `i_data` directly.
- Short groups, ended by `i_last`, are padded with the signed-min identity so the reduction result is unaffected.

Parameters:
- WIDTH, 1, bits per element (signed two's complement).
- COUNT, 1, elements per output vector; must be >= 1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_data_valid  input  1  input word present this cycle; always accepted, there is no backpressure.
- i_data  input  WIDTH  input word.
- i_last  input  1  qualified by `i_data_valid`; this word closes the current group.
- o_data_valid  output  1  one-cycle pulse: `o_data` holds a complete vector.
- o_data  output  [COUNT-1:0][WIDTH-1:0]  packed vector; element 0 is the first word of the group.

Behaviour:
- PAD = signed maximum of WIDTH bits (MSB 0, all other bits 1). For WIDTH=1, PAD = 0.
- Working state:
  - Buffer `buf[COUNT]`, all PAD at reset.
  - Slot index `idx`, width max(1, $clog2(COUNT)), 0 at reset.
- Two states:
  - EMPTY: idx==0, buf all PAD.
  - FILL: idx>0.
- On each accepted word (`i_data_valid`=1):
  - The word is written to `buf[idx]`.
  - If idx==COUNT-1 or `i_last`=1, the group closes:
    - Next cycle: `o_data` = buf with the new word merged in at idx; slots above idx = PAD; `o_data_valid`=1.
    - buf returns to all PAD; idx returns to 0 (EMPTY).
  - Otherwise idx increments (FILL).
- Latency: exactly 1 cycle from the closing word to the `o_data_valid` pulse.
- Throughput:
  - One word per cycle, sustained.
  - A word arriving the cycle after a close lands in slot 0 of the fresh group. No bubble is required or inserted.
- `i_data_valid`=0: no state change; `o_data_valid`=0 next cycle.
- `i_last` with `i_data_valid`=0 is ignored.
- `o_data` holds its last emitted value while `o_data_valid`=0.
- COUNT==1: every accepted word emits next cycle; `i_last` has no effect; idx is held at 0.
- `i_last` on the COUNT-th word: a single close, no extra empty vector.
- Reset:
  - Values: `o_data_valid`=0, `o_data` all PAD, buf all PAD, idx=0.
  - A partial group in progress is discarded and never emitted.
  - Reset has priority over a simultaneous valid word; that word is dropped.
- Arithmetic: none on data. Words are stored bit-exact; padding is the only generated value.

Optional Feature:
- Macro: SVNET_TREE_PACK_COUNT_EN.
- When defined:
  - Extra output `o_count`, width $clog2(COUNT+1).
  - Holds the number of real (non-PAD) elements in `o_data`.
  - Updated with `o_data_valid`, held otherwise, reset to 0.
- When undefined: the port and its counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `svnet_pkg`:
  - Constant function `svnet_pad_max(width)` returning PAD.
  - Latency constant SVNET_TREE_PACK_DELAY = 1.
- No sub-module: a single flat module with one always_ff for buf/idx and one for the output registers.

Test Plan:
- WIDTH=8, COUNT=4, words 0x05,0xFE,0x10,0x03 on consecutive cycles -> one cycle after 0x03: `o_data_valid`=1, `o_data`={0x03,0x10,0xFE,0x05} (elements 3..0); `o_count`=4 if enabled.
- Words 0x11, 0x22 with `i_last` on 0x22 -> next cycle `o_data`={0x7F,0x7F,0x22,0x11}, `o_count`=2; a following single word 0x80 with `i_last` -> {0x7F,0x7F,0x7F,0x80}.
- 8 back-to-back valid words 1..8, no `i_last` -> pulses exactly 4 cycles apart carrying {4,3,2,1} then {8,7,6,5}; `o_data_valid` low on all other cycles.
- Words 0x01,0x02,0x03,0x04 with 2 idle cycles between each -> a single pulse with {0x04,0x03,0x02,0x01}; `o_data` unchanged across the idle cycles.
- Reset asserted after 2 words (0xAA,0xBB) of a group, then words 0x01..0x04 -> no emission of 0xAA/0xBB; the only pulse carries {0x04,0x03,0x02,0x01}.
- COUNT=1, WIDTH=4, words 0x7,0x8 consecutive, `i_last` toggled randomly -> pulses on the two following cycles with 0x7 then 0x8.
